// File: rtl/dvp_rgb565_capture.sv
// DVP camera capture: pairs bytes into RGB565 pixels, drops
// settling frames and flags line/frame geometry errors.
module dvp_rgb565_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] rgb565,
  output logic        pix_valid,
  output logic [10:0] x_cnt,
  output logic [10:0] y_cnt,
  output logic        frame_start,
  output logic        line_err,
  output logic        frame_err,
  output logic        capturing
);

  localparam logic [10:0] H_N  = 11'(H_ACTIVE);
  localparam logic [10:0] V_N  = 11'(V_ACTIVE);
  localparam logic [7:0]  S_N  = 8'(SKIP_FRAMES);
  localparam logic [10:0] CMAX = 11'h7ff;

  typedef enum logic [1:0] {
    WAIT_VS,
    SKIP,
    ACTIVE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  skip_cnt;
  logic [7:0]  skip_nx;

  logic        vs_r;
  logic        vs_r2;
  logic        hr_r;
  logic        hr_r2;
  logic [7:0]  d_r;

  logic        vs_rise;
  logic        hr_fall;
  logic        active;
  logic        pair;
  logic        phase;
  logic        first_fr;
  logic [7:0]  hi_byte;

  logic        pend_v;
  logic [15:0] pend_d;
  logic [10:0] pend_x;
  logic [10:0] pend_y;

  logic [10:0] col;
  logic [10:0] row;
  logic [10:0] row_done;

  assign vs_rise   = vs_r & ~vs_r2;
  assign hr_fall   = ~hr_r & hr_r2;
  assign active    = (state == ACTIVE);
  assign capturing = active;

  // A pair completing on a frame boundary is dropped with the phase.
  assign pair = active & hr_r & phase & ~vs_rise;

  // Line closing on the same edge as vsync is counted before the check.
  assign row_done = (hr_fall && row != CMAX) ? row + 11'd1 : row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_VS;
      skip_cnt <= '0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
    end
  end

  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    unique case (state)
      WAIT_VS: begin
        if (vs_rise) begin
          state_nx = (S_N == 8'd0) ? ACTIVE : SKIP;
        end
      end
      SKIP: begin
        if (vs_rise) begin
          if (skip_cnt + 8'd1 >= S_N) begin
            state_nx = ACTIVE;
            skip_nx  = '0;
          end else begin
            skip_nx = skip_cnt + 8'd1;
          end
        end
      end
      ACTIVE: begin
        state_nx = ACTIVE;
      end
      default: begin
        state_nx = WAIT_VS;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_r     <= 1'b0;
      vs_r2    <= 1'b0;
      hr_r     <= 1'b0;
      hr_r2    <= 1'b0;
      d_r      <= '0;
      phase    <= 1'b0;
      hi_byte  <= '0;
      first_fr <= 1'b0;
      pend_v   <= 1'b0;
      pend_d   <= '0;
      pend_x   <= '0;
      pend_y   <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      vs_r  <= cam_vsync;
      vs_r2 <= vs_r;
      hr_r  <= cam_href;
      hr_r2 <= hr_r;
      d_r   <= cam_data;

      if (vs_rise || hr_fall) begin
        phase <= 1'b0;
      end else if (active && hr_r) begin
        phase <= ~phase;
      end

      if (active && hr_r && !phase) begin
        hi_byte <= d_r;
      end

      if (state != ACTIVE && state_nx == ACTIVE) begin
        first_fr <= 1'b1;
      end else if (active && vs_rise) begin
        first_fr <= 1'b0;
      end

      pend_v <= pair;
      if (pair) begin
        pend_d <= {hi_byte, d_r};
        pend_x <= col;
        pend_y <= row;
      end

      if (vs_rise || hr_fall) begin
        col <= '0;
      end else if (pair && col != CMAX) begin
        col <= col + 11'd1;
      end

      if (vs_rise) begin
        row <= '0;
      end else if (hr_fall && row != CMAX) begin
        row <= row + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb565      <= '0;
      pix_valid   <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_valid <= pend_v;
      if (pend_v) begin
        rgb565 <= pend_d;
        x_cnt  <= pend_x;
        y_cnt  <= pend_y;
      end else begin
        if (active && hr_fall) begin
          x_cnt <= '0;
        end
        if (active && vs_rise) begin
          y_cnt <= '0;
        end
      end

      line_err    <= active & hr_fall &
                     ((col != H_N) | phase);
      frame_start <= active & vs_rise;
      frame_err   <= active & vs_rise & ~first_fr &
                     (row_done != V_N);
    end
  end

endmodule
